// File: rtl/pe_driver.sv
// Feeds operand requests to a fixed-latency PE and returns its results in order.
// In-flight launches are tracked so the result buffer can never overflow.
module pe_driver #(
  parameter int PE_LAT = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_mode,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        flush,
  output logic [1:0]  pe_mode,
  output logic [15:0] pe_mult0,
  output logic [15:0] pe_mult1,
  input  logic [31:0] pe_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_mode,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(PE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  state_t          state_next;
  logic [PE_LAT-1:0] vld_sr;
  logic [1:0]      mode_sr [PE_LAT];
  logic [IW-1:0]   inflight;
  logic [33:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      occupancy;
  logic            accept;
  logic            launch;
  logic            wr_en;
  logic            rd_en;
  logic            pending;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PE_LAT; i++) begin
      inflight = inflight + IW'(vld_sr[i]);
    end
  end

  // Reserve space for every launch still inside the PE, not just buffered results.
  assign occupancy = 8'(count) + 8'(inflight);
  assign in_ready  = rst_n && (state != DRAIN) && !flush && (occupancy < 8'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign launch    = accept && (in_mode != 2'b11);
  assign wr_en     = vld_sr[PE_LAT-1];
  assign rd_en     = out_valid && out_ready;
  assign pending   = (inflight != '0) || (count != '0);

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr][31:0]  : 32'h0;
  assign out_mode  = out_valid ? mem[rd_ptr][33:32] : 2'b00;
  assign busy      = (state != IDLE);

  // Operands are cleared on any edge without a launch so the PE never sees stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_mode  <= 2'b11;
      pe_mult0 <= '0;
      pe_mult1 <= '0;
      err      <= 1'b0;
    end else begin
      pe_mode  <= launch ? in_mode : 2'b11;
      pe_mult0 <= launch ? in_a : 16'h0;
      pe_mult1 <= launch ? in_b : 16'h0;
      if (accept && (in_mode == 2'b11)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < PE_LAT; i++) begin
        mode_sr[i] <= 2'b00;
      end
    end else begin
      for (int i = PE_LAT - 1; i > 0; i--) begin
        vld_sr[i]  <= vld_sr[i-1];
        mode_sr[i] <= mode_sr[i-1];
      end
      vld_sr[0]  <= launch;
      mode_sr[0] <= in_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {mode_sr[PE_LAT-1], pe_result};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        if (flush && pending) state_next = DRAIN;
        else if (!pending && !accept) state_next = IDLE;
      end
      DRAIN: begin
        if (!pending) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_driver.sv
// Self-checking bench for pe_driver with a one-register PE model behind the
// driver's operand registers; results are checked through an in-order scoreboard.
module tb_pe_driver;

  localparam int PE_LAT = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        flush;
  logic [1:0]  pe_mode;
  logic [15:0] pe_mult0;
  logic [15:0] pe_mult1;
  logic [31:0] pe_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic        busy;
  logic        err;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [33:0] sb_q [$];
  logic [33:0] sb_exp;

  always #5 clk = ~clk;

  pe_driver #(.PE_LAT(PE_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .flush(flush),
    .pe_mode(pe_mode), .pe_mult0(pe_mult0), .pe_mult1(pe_mult1),
    .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode), .busy(busy), .err(err)
  );

  function automatic logic [31:0] pe_func(input logic [1:0] m, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] r;
    case (m)
      2'b00:   r = {16'h0, a} + {16'h0, b};
      2'b01:   r = {16'h0, a} * {16'h0, b};
      2'b10:   r = {a, b};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // PE: one register stage after the driver's operand register
  always @(posedge clk) pe_result <= pe_func(pe_mode, pe_mult0, pe_mult1);

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
      end else begin
        if (in_valid && in_ready && in_mode != 2'b11)
          sb_q.push_back({in_mode, pe_func(in_mode, in_a, in_b)});
        if (out_valid && out_ready) begin
          tests_run++;
          if (sb_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL sb_unexpected: got mode=%b data=%h, required no output",
                     out_mode, out_data);
          end else begin
            sb_exp = sb_q.pop_front();
            if ({out_mode, out_data} !== sb_exp) begin
              tests_failed++;
              $display("[TB] FAIL sb_order: got mode=%b data=%h, required mode=%b data=%h",
                       out_mode, out_data, sb_exp[33:32], sb_exp[31:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    int waitc = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waitc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({pe_mode, pe_mult0, pe_mult1, out_valid, out_data, out_mode, in_ready, busy, err} !==
        {2'b11, 16'h0, 16'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got pe_mode=%b m0=%h m1=%h ov=%b od=%h om=%b rdy=%b busy=%b err=%b, required 11/0/0/0/0/0/0/0/0",
               pe_mode, pe_mult0, pe_mult1, out_valid, out_data, out_mode, in_ready, busy, err);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(2'b01, 16'h0111, 16'h0202);
    tests_run++;
    if ({pe_mode, pe_mult0, pe_mult1} !== {2'b01, 16'h0111, 16'h0202}) begin
      tests_failed++;
      $display("[TB] FAIL single_launch: got %b %h %h, required 01 0111 0202", pe_mode, pe_mult0, pe_mult1);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({pe_mode, pe_mult0, pe_mult1, out_valid} !== {2'b11, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL single_idle_ops: got %b %h %h ov=%b, required 11 0000 0000 ov=0",
               pe_mode, pe_mult0, pe_mult1, out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, out_mode, out_data} !== {1'b1, 2'b01, 32'h00022422}) begin
      tests_failed++;
      $display("[TB] FAIL single_result: got ov=%b mode=%b data=%h, required 1 01 00022422",
               out_valid, out_mode, out_data);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, out_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL single_idle: got busy=%b ov=%b, required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int waitc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_mode  = 2'b01;
      in_a     = 16'(16'h10 + i);
      in_b     = 16'h3;
      tests_run++;
      if (in_ready !== (i < 4)) begin
        tests_failed++;
        $display("[TB] FAIL bp_ready_%0d: got %b, required %b", i, in_ready, (i < 4));
      end
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (acc != 4 || {out_valid, in_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL bp_full: got accepts=%0d ov=%b rdy=%b, required 4/1/0", acc, out_valid, in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, out_mode, out_data} !== {1'b1, 2'b01, 32'h00000030}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold: got ov=%b mode=%b data=%h, required 1 01 00000030",
                 out_valid, out_mode, out_data);
      end
    end
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && waitc < 40) begin
      @(posedge clk); #1;
      waitc++;
    end
    tests_run++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_drain: got pending=%0d ov=%b, required 0/0", sb_q.size(), out_valid);
    end
  endtask

  task automatic test_reserved();
    int seen = 0;
    out_ready = 1'b1;
    send(2'b11, 16'h1234, 16'h5678);
    tests_run++;
    if ({pe_mode, pe_mult0, pe_mult1, err} !== {2'b11, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL reserved_launch: got %b %h %h err=%b, required 11 0000 0000 err=1",
               pe_mode, pe_mult0, pe_mult1, err);
    end
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen != 0 || err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reserved_no_out: got out_valid cycles=%0d err=%b, required 0/1", seen, err);
    end
  endtask

  task automatic test_flush();
    int waitc = 0;
    out_ready = 1'b1;
    send(2'b01, 16'h0005, 16'h0006);
    send(2'b10, 16'hABCD, 16'h1357);
    flush = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, busy} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL flush_ready: got rdy=%b busy=%b, required 0/1", in_ready, busy);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, busy} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL flush_drain_state: got rdy=%b busy=%b, required 0/1", in_ready, busy);
    end
    while (busy && waitc < 40) begin
      @(posedge clk); #1;
      waitc++;
    end
    tests_run++;
    if (busy !== 1'b0 || sb_q.size() != 0 || {out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL flush_done: got busy=%b pending=%0d ov=%b rdy=%b, required 0/0/0/1",
               busy, sb_q.size(), out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b0;
    send(2'b01, 16'h0007, 16'h0009);
    send(2'b00, 16'h1111, 16'h2222);
    send(2'b10, 16'h3333, 16'h4444);
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({pe_mode, pe_mult0, pe_mult1, out_valid, out_data, out_mode, in_ready, busy, err} !==
        {2'b11, 16'h0, 16'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL midreset_values: got pe_mode=%b m0=%h m1=%h ov=%b od=%h om=%b rdy=%b busy=%b err=%b, required 11/0/0/0/0/0/0/0/0",
               pe_mode, pe_mult0, pe_mult1, out_valid, out_data, out_mode, in_ready, busy, err);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen != 0 || {in_ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL midreset_release: got out_valid cycles=%0d rdy=%b busy=%b, required 0/1/0",
               seen, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int waitc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_mode  = 2'(i % 3);
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL b2b_ready_%0d: got %b, required 1", i, in_ready);
      end
      if (i >= 3) begin
        tests_run++;
        if (out_valid !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL b2b_out_%0d: got ov=%b, required 1", i, out_valid);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    while ((sb_q.size() != 0 || busy) && waitc < 40) begin
      @(posedge clk); #1;
      waitc++;
    end
    tests_run++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_drain: got pending=%0d busy=%b, required 0/0", sb_q.size(), busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    fork
      monitor();
      begin
        #200000;
        tests_failed++;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
      end
    join_none
    test_reset();
    test_single();
    test_backpressure();
    test_reserved();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
